// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB full-speed transmit line encoder.
package usb_tx_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DATA    = 2'd1,
    EOP_SE0 = 2'd2,
    EOP_J   = 2'd3
  } tx_state_t;

  // Line levels as {dp, dm}
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  // Bit times of SE0 that open the end-of-packet
  localparam int EOP_SE0_BITS = 2;

  // Consecutive 1s after which a stuffed 0 is forced
  localparam int DEFAULT_MAX_ONES = 6;

  // NRZI transition: a transmitted 0 swaps J and K
  function automatic logic [1:0] nrzi_toggle(input logic [1:0] line);
    logic [1:0] res;
    if (line == LINE_J) begin
      res = LINE_K;
    end else begin
      res = LINE_J;
    end
    return res;
  endfunction

endpackage

// File: rtl/usb_bit_tick_gen.sv
// Bit-time divider: counts 0..CLKS_PER_BIT-1 and flags the last count as the
// bit tick. Held at zero while i_clr is high so the first tick after a clear
// lands exactly CLKS_PER_BIT cycles later.
module usb_bit_tick_gen #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic nRST,
  input  logic i_clr,
  output logic o_tick
);

  localparam int W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  logic [W-1:0] r_div_cnt;
  logic         w_tick;

  assign w_tick = (r_div_cnt == W'(CLKS_PER_BIT - 1));
  assign o_tick = w_tick;

  // Divider counter with clear and wrap at the end of each bit time
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_div_cnt <= '0;
    end else if (i_clr || w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + W'(1);
    end
  end

endmodule

// File: rtl/usb_tx_bitstuff_nrzi.sv
// USB full-speed transmit back end: bit stuffing, NRZI line coding, EOP
// generation and output enable. Paces the upstream shifter with bit_ack.
module usb_tx_bitstuff_nrzi
  import usb_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int MAX_ONES     = DEFAULT_MAX_ONES
) (
  input  logic clk,
  input  logic nRST,
  input  logic tx_start,
  input  logic bit_in,
  input  logic bit_valid,
  input  logic eop_req,
  output logic bit_ack,
  output logic dp,
  output logic dm,
  output logic oe,
  output logic busy,
  output logic underrun
);

  localparam int OW = $clog2(MAX_ONES + 1);

  tx_state_t     r_state;
  logic [1:0]    r_line;
  logic          r_oe;
  logic          r_busy;
  logic          r_bit_ack;
  logic          r_underrun;
  logic [OW-1:0] r_ones_cnt;
  logic [1:0]    r_se0_cnt;

  tx_state_t     w_state_nxt;
  logic [1:0]    w_line_nxt;
  logic          w_oe_nxt;
  logic          w_busy_nxt;
  logic          w_ack_nxt;
  logic          w_underrun_nxt;
  logic [OW-1:0] w_ones_nxt;
  logic [1:0]    w_se0_nxt;
  logic          w_tick;

  usb_bit_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .clk   (clk),
    .nRST  (nRST),
    .i_clr (r_state == IDLE),
    .o_tick(w_tick)
  );

  // State register and registered outputs
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_state    <= IDLE;
      r_line     <= LINE_J;
      r_oe       <= 1'b0;
      r_busy     <= 1'b0;
      r_bit_ack  <= 1'b0;
      r_underrun <= 1'b0;
      r_ones_cnt <= '0;
      r_se0_cnt  <= 2'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_line     <= w_line_nxt;
      r_oe       <= w_oe_nxt;
      r_busy     <= w_busy_nxt;
      r_bit_ack  <= w_ack_nxt;
      r_underrun <= w_underrun_nxt;
      r_ones_cnt <= w_ones_nxt;
      r_se0_cnt  <= w_se0_nxt;
    end
  end

  // Next-state and next-output decode; line only moves on a tick or at IDLE edges
  always_comb begin
    w_state_nxt    = r_state;
    w_line_nxt     = r_line;
    w_oe_nxt       = r_oe;
    w_busy_nxt     = r_busy;
    w_ack_nxt      = 1'b0;
    w_underrun_nxt = 1'b0;
    w_ones_nxt     = r_ones_cnt;
    w_se0_nxt      = r_se0_cnt;

    case (r_state)
      IDLE: begin
        w_line_nxt = LINE_J;
        w_ones_nxt = '0;
        w_se0_nxt  = 2'd0;
        if (tx_start) begin
          w_state_nxt = DATA;
          w_oe_nxt    = 1'b1;
          w_busy_nxt  = 1'b1;
        end else begin
          w_state_nxt = IDLE;
          w_oe_nxt    = 1'b0;
          w_busy_nxt  = 1'b0;
        end
      end

      DATA: begin
        if (w_tick) begin
          if (r_ones_cnt == OW'(MAX_ONES)) begin
            // Stuffed 0 wins over everything, so it always precedes EOP
            w_line_nxt = nrzi_toggle(r_line);
            w_ones_nxt = '0;
          end else if (bit_valid) begin
            w_ack_nxt = 1'b1;
            if (bit_in) begin
              w_ones_nxt = r_ones_cnt + OW'(1);
            end else begin
              w_line_nxt = nrzi_toggle(r_line);
              w_ones_nxt = '0;
            end
          end else begin
            // Missing data is closed out like a requested EOP
            if (eop_req) begin
              w_underrun_nxt = 1'b0;
            end else begin
              w_underrun_nxt = 1'b1;
            end
            w_state_nxt = EOP_SE0;
            w_line_nxt  = LINE_SE0;
            w_se0_nxt   = 2'd0;
          end
        end else begin
          w_state_nxt = DATA;
        end
      end

      EOP_SE0: begin
        if (w_tick) begin
          if (r_se0_cnt == 2'(EOP_SE0_BITS - 1)) begin
            w_state_nxt = EOP_J;
            w_line_nxt  = LINE_J;
            w_se0_nxt   = 2'd0;
          end else begin
            w_se0_nxt = r_se0_cnt + 2'd1;
          end
        end else begin
          w_state_nxt = EOP_SE0;
        end
      end

      EOP_J: begin
        if (w_tick) begin
          w_state_nxt = IDLE;
          w_line_nxt  = LINE_J;
          w_oe_nxt    = 1'b0;
          w_busy_nxt  = 1'b0;
        end else begin
          w_state_nxt = EOP_J;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_line_nxt  = LINE_J;
        w_oe_nxt    = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign dp       = r_line[1];
  assign dm       = r_line[0];
  assign oe       = r_oe;
  assign busy     = r_busy;
  assign bit_ack  = r_bit_ack;
  assign underrun = r_underrun;

endmodule

// File: tb/tb_usb_tx_bitstuff_nrzi.sv
// Directed plus randomized bench for usb_tx_bitstuff_nrzi. Expected line
// symbols come from a queue-based model of stuffing and NRZI.
module tb_usb_tx_bitstuff_nrzi;

  localparam int CPB  = 4;
  localparam int MAXO = 6;

  logic clk = 1'b0;
  logic nRST = 1'b0;
  logic tx_start = 1'b0;
  logic bit_in = 1'b0;
  logic bit_valid = 1'b0;
  logic eop_req = 1'b0;
  logic bit_ack, dp, dm, oe, busy, underrun;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  bit         data_q[$];
  logic [1:0] exp_q[$];

  usb_tx_bitstuff_nrzi #(
    .CLKS_PER_BIT(CPB),
    .MAX_ONES    (MAXO)
  ) dut (
    .clk      (clk),
    .nRST     (nRST),
    .tx_start (tx_start),
    .bit_in   (bit_in),
    .bit_valid(bit_valid),
    .eop_req  (eop_req),
    .bit_ack  (bit_ack),
    .dp       (dp),
    .dm       (dm),
    .oe       (oe),
    .busy     (busy),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: symbol per bit slot after the start J, ending with SE0,SE0,J
  function automatic void build_expected();
    logic [1:0] lvl = 2'b10;
    int ones = 0;
    exp_q.delete();
    foreach (data_q[i]) begin
      if (ones == MAXO) begin
        lvl = ~lvl;
        exp_q.push_back(lvl);
        ones = 0;
      end
      if (data_q[i]) begin
        ones++;
      end else begin
        lvl = ~lvl;
        ones = 0;
      end
      exp_q.push_back(lvl);
    end
    if (ones == MAXO) begin
      lvl = ~lvl;
      exp_q.push_back(lvl);
    end
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b10);
  endfunction

  task automatic load_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) data_q.push_back(b[i]);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends data_q as one packet starting in the current cycle; returns in the
  // first IDLE cycle after EOP so the next packet can start back-to-back.
  task automatic run_packet(input string name, input bit um, input bit poke);
    int n, idx, acks, urs, nsym, limit, slot, phase;
    bit done;
    n = data_q.size();
    build_expected();
    nsym = exp_q.size();
    tx_start = 1'b1;
    idx = 0;
    bit_valid = (n > 0);
    if (n > 0) bit_in = data_q[0];
    else bit_in = 1'b0;
    eop_req = (n == 0) && !um;
    acks = 0;
    urs = 0;
    done = 1'b0;
    limit = CPB * (nsym + 3);
    for (int cyc = 1; cyc <= limit && !done; cyc++) begin
      @(posedge clk);
      #1;
      tx_start = poke && (cyc == 6);
      if (bit_ack === 1'b1) begin
        acks++;
        idx++;
        if (idx < n) begin
          bit_in = data_q[idx];
        end else begin
          bit_valid = 1'b0;
          bit_in = 1'b0;
          eop_req = !um;
        end
      end
      if (underrun === 1'b1) urs++;
      slot = (cyc - 1) / CPB;
      phase = (cyc - 1) % CPB;
      if (slot == nsym + 1) begin
        chk({name, "_end_idle"}, 32'({dp, dm, oe, busy}), 32'(4'b1000));
        done = 1'b1;
      end else if (phase == 1) begin
        if (slot == 0) chk({name, "_start_J"}, 32'({dp, dm, oe, busy}), 32'(4'b1011));
        else chk({name, "_line"}, 32'({dp, dm, oe, busy}), 32'({exp_q[slot-1], 2'b11}));
      end
    end
    if (!done) chk({name, "_timeout"}, 32'(0), 32'(1));
    chk({name, "_acks"}, 32'(acks), 32'(n));
    chk({name, "_underruns"}, 32'(urs), 32'(um ? 1 : 0));
    tx_start = 1'b0;
  endtask

  initial begin
    int len;
    // Reset state
    cycles(3);
    chk("reset_state", 32'({dp, dm, oe, busy, bit_ack, underrun}), 32'(6'b100000));
    nRST = 1'b1;
    cycles(2);
    chk("post_reset_idle", 32'({dp, dm, oe, busy}), 32'(4'b1000));

    // Reset in the middle of a packet must return the line to J immediately
    tx_start = 1'b1;
    bit_valid = 1'b1;
    bit_in = 1'b0;
    cycles(1);
    tx_start = 1'b0;
    cycles(9);
    chk("midpkt_busy", 32'({oe, busy}), 32'(2'b11));
    nRST = 1'b0;
    #1;
    chk("midpkt_reset", 32'({dp, dm, oe, busy}), 32'(4'b1000));
    bit_valid = 1'b0;
    cycles(2);
    nRST = 1'b1;
    cycles(3);
    chk("after_reset_idle", 32'({dp, dm, oe, busy}), 32'(4'b1000));

    // Sync byte, with a tx_start poke while busy that must be ignored
    data_q.delete();
    load_byte(8'h80);
    run_packet("sync80", 1'b0, 1'b1);
    cycles(2);

    // All ones forces a stuffed bit; next packet starts back-to-back
    data_q.delete();
    load_byte(8'hFF);
    run_packet("ffbyte", 1'b0, 1'b0);

    // Six 1s then EOP: stuff must precede SE0
    data_q.delete();
    for (int i = 0; i < MAXO; i++) data_q.push_back(1'b1);
    run_packet("six_ones", 1'b0, 1'b0);
    cycles(1);

    // tx_start together with eop_req gives a zero-data packet
    data_q.delete();
    run_packet("zero_data", 1'b0, 1'b0);
    cycles(1);

    // Randomized packets biased toward 1s to exercise stuffing
    for (int p = 0; p < 4; p++) begin
      data_q.delete();
      len = $urandom_range(1, 24);
      for (int i = 0; i < len; i++) data_q.push_back($urandom_range(0, 3) != 0);
      run_packet("random", 1'b0, 1'b0);
      cycles($urandom_range(0, 3));
    end

    // Underrun: data and eop_req both vanish after random bits
    data_q.delete();
    len = $urandom_range(3, 12);
    for (int i = 0; i < len; i++) data_q.push_back($urandom_range(0, 1) != 0);
    run_packet("underrun", 1'b1, 1'b1);
    cycles(2);
    chk("final_idle", 32'({dp, dm, oe, busy, underrun}), 32'(5'b10000));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
